conv_ibuf: RTL

- Downstream stage of the conv activation/accumulate block.
- Collects one output pixel at a time: OUTPUT_CHANNELS values, written in chunks under per-channel write enables and committed by a start pulse.
- Stores pixels in a KERNEL_DIM-row circular line buffer.
- Once a full KERNEL_DIM x KERNEL_DIM x CHANNELS window exists (stride 1, no padding), presents it flattened to the next layer's CIM input with a start/ready handshake.

---
 rtl/conv_ibuf_pkg.sv | 18 +
 rtl/conv_ibuf_linebuf.sv | 55 +++++
 rtl/conv_ibuf.sv | 138 +++++++++++++
 3 files changed

// File: rtl/conv_ibuf_pkg.sv
// Shared types and sizing helpers for the conv input line buffer.
package conv_ibuf_pkg;

    typedef enum logic [1:0] {
        s_conv_ibuf_idle,
        s_conv_ibuf_gather,
        s_conv_ibuf_emit
    } t_conv_ibuf_state;

    function automatic int win_size(input int kernel_dim, input int channels);
        return kernel_dim * kernel_dim * channels;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_ibuf_linebuf.sv
// KERNEL_DIM-row circular pixel store with one pixel write port and a
// combinational read of the full window ending at the newest (row, col).
module conv_ibuf_linebuf
    import conv_ibuf_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int CHANNELS   = 4,
    parameter int KERNEL_DIM = 3,
    parameter int IMG_DIM    = 8,
    parameter int WIN_SIZE   = win_size(KERNEL_DIM, CHANNELS),
    parameter int ROW_W      = idx_width(KERNEL_DIM),
    parameter int COL_W      = idx_width(IMG_DIM)
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [ROW_W-1:0]     i_wr_row,
    input  logic [COL_W-1:0]     i_wr_col,
    input  logic [DATA_SIZE-1:0] i_wr_pixel [CHANNELS],
    input  logic [COL_W-1:0]     i_rd_row,
    input  logic [COL_W-1:0]     i_rd_col,
    output logic [DATA_SIZE-1:0] o_window [WIN_SIZE]
);

    logic [DATA_SIZE-1:0] r_mem [KERNEL_DIM][IMG_DIM][CHANNELS];
    logic [ROW_W-1:0]     w_rd_row;
    logic [COL_W-1:0]     w_rd_col;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_mem[i_wr_row][i_wr_col][c] <= i_wr_pixel[c];
            end
        end
    end

    // Absolute row (newest-K+1+ky) mod K reduces to (newest+1+ky) mod K.
    always_comb begin
        w_rd_row = '0;
        w_rd_col = '0;
        for (int i = 0; i < WIN_SIZE; i++) begin
            o_window[i] = '0;
        end
        for (int ky = 0; ky < KERNEL_DIM; ky++) begin
            for (int kx = 0; kx < KERNEL_DIM; kx++) begin
                w_rd_row = ROW_W'((int'(i_rd_row) + 1 + ky) % KERNEL_DIM);
                w_rd_col = (int'(i_rd_col) + kx >= KERNEL_DIM - 1)
                         ? COL_W'(int'(i_rd_col) + kx - (KERNEL_DIM - 1)) : '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    o_window[(ky * KERNEL_DIM + kx) * CHANNELS + c] = r_mem[w_rd_row][w_rd_col][c];
                end
            end
        end
    end

endmodule

// File: rtl/conv_ibuf.sv
// Pixel staging, raster counters and window handshake in front of the
// next layer's CIM input.
module conv_ibuf
    import conv_ibuf_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int CHANNELS   = 4,
    parameter int KERNEL_DIM = 3,
    parameter int IMG_DIM    = 8,
    parameter int WIN_SIZE   = win_size(KERNEL_DIM, CHANNELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] i_data [CHANNELS],
    input  logic [CHANNELS-1:0]  i_write_enable,
    input  logic                 i_start,
    output logic                 o_ready,
    input  logic                 i_next_ready,
    output logic [DATA_SIZE-1:0] o_data [WIN_SIZE],
    output logic                 o_start,
    output logic                 o_last
);

    localparam int ROW_W = idx_width(KERNEL_DIM);
    localparam int COL_W = idx_width(IMG_DIM);
    localparam logic [COL_W-1:0] LAST_IDX = COL_W'(IMG_DIM - 1);
    localparam logic [COL_W-1:0] K_IDX    = COL_W'(KERNEL_DIM - 1);

    t_conv_ibuf_state     r_state, w_next_state;
    logic [DATA_SIZE-1:0] r_stage  [CHANNELS];
    logic [DATA_SIZE-1:0] w_pixel  [CHANNELS];
    logic [DATA_SIZE-1:0] w_window [WIN_SIZE];
    logic [COL_W-1:0]     r_row, r_col, r_win_row, r_win_col;
    logic [ROW_W-1:0]     w_wr_row;
    logic                 w_commit, w_window_hit, r_last;

    // Same-cycle write enables take priority over the staged value.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_pixel[c] = i_write_enable[c] ? i_data[c] : r_stage[c];
        end
    end

    assign w_commit     = i_start && o_ready;
    assign w_window_hit = (r_row >= K_IDX) && (r_col >= K_IDX);
    assign w_wr_row     = ROW_W'(int'(r_row) % KERNEL_DIM);
    assign o_last       = o_start && r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= s_conv_ibuf_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_ready      = 1'b0;
        o_start      = 1'b0;
        case (r_state)
            s_conv_ibuf_idle: begin
                o_ready = 1'b1;
                if (i_start && w_window_hit) begin
                    w_next_state = s_conv_ibuf_gather;
                end
            end
            s_conv_ibuf_gather: begin
                w_next_state = s_conv_ibuf_emit;
            end
            s_conv_ibuf_emit: begin
                if (i_next_ready) begin
                    o_start      = 1'b1;
                    w_next_state = s_conv_ibuf_idle;
                end
            end
            default: begin
                w_next_state = s_conv_ibuf_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_win_row <= '0;
            r_win_col <= '0;
            r_last    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_stage[c] <= '0;
            end
            for (int i = 0; i < WIN_SIZE; i++) begin
                o_data[i] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_stage[c] <= w_pixel[c];
            end
            if (w_commit) begin
                r_win_row <= r_row;
                r_win_col <= r_col;
                if (r_col == LAST_IDX) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST_IDX) ? '0 : r_row + COL_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
            if (r_state == s_conv_ibuf_gather) begin
                for (int i = 0; i < WIN_SIZE; i++) begin
                    o_data[i] <= w_window[i];
                end
                r_last <= (r_win_row == LAST_IDX) && (r_win_col == LAST_IDX);
            end
        end
    end

    conv_ibuf_linebuf #(
        .DATA_SIZE  (DATA_SIZE),
        .CHANNELS   (CHANNELS),
        .KERNEL_DIM (KERNEL_DIM),
        .IMG_DIM    (IMG_DIM),
        .WIN_SIZE   (WIN_SIZE),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_linebuf (
        .clk        (clk),
        .i_wr_en    (w_commit),
        .i_wr_row   (w_wr_row),
        .i_wr_col   (r_col),
        .i_wr_pixel (w_pixel),
        .i_rd_row   (r_win_row),
        .i_rd_col   (r_win_col),
        .o_window   (w_window)
    );

endmodule
